// File: rtl/scoreboard_counter_multi.sv
// scoreboard_counter_multi
//
// Register-dependency scoreboard for the issue stage. Each architectural
// register (except register 0, which is hardwired and never busy) owns a
// saturating pending-write counter. Issue increments the counter of the
// destination register, writeback/commit decrements it, and any number of
// query ports report whether a register still has writes in flight.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears all counters and sb_err
//   rdy       global enable; when low all state holds (flush still acts)
//   flush     clears every counter, overrides all other updates
//   wr_en     issue of an instruction that writes wr_addr
//   wr_addr   destination register at issue
//   wr_full   counter[wr_addr] is at its maximum, issue must stall
//   fin_en    a write to fin_addr has completed
//   fin_addr  completed destination register
//   rd_en     per-port query enable
//   rd_addr   packed query addresses, port i at [i*LOG_REG_CNT +: LOG_REG_CNT]
//   rd_busy   port i: rd_en[i] and the counter is nonzero
//   rd_cnt    port i: counter value, 0 when rd_en[i] is low
//   sb_err    sticky protocol error (overflow / underflow attempt)
//
// Optional feature macro: SCOREBOARD_ERR_CHECK_EN
//   defined   -> sb_err latches on an issue to a full counter or a finish to
//                an empty counter (same-address issue+finish pairs excluded)
//   undefined -> no check logic, sb_err is tied low
//
// All outputs are combinational from the counter state; there is no bypass,
// so an update is visible one cycle after the edge that applies it.

module scoreboard_counter_multi #(
  parameter int REG_CNT     = 32,
  parameter int LOG_REG_CNT = 5,
  parameter int CNT_W       = 3,
  parameter int NUM_RD      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [LOG_REG_CNT-1:0]        wr_addr,
  output logic                          wr_full,
  input  logic                          fin_en,
  input  logic [LOG_REG_CNT-1:0]        fin_addr,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD*LOG_REG_CNT-1:0] rd_addr,
  output logic [NUM_RD-1:0]             rd_busy,
  output logic [NUM_RD*CNT_W-1:0]       rd_cnt,
  output logic                          sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register 0 has no storage; its counter is implicitly zero.
  logic [CNT_W-1:0] cnt_q [1:REG_CNT-1];
  logic [CNT_W-1:0] cnt_d [1:REG_CNT-1];

  // One-hot decode of the issue and finish addresses. Address 0 and any
  // address at or beyond REG_CNT decode to no bit at all, which is how those
  // addresses end up ignored without extra special-casing.
  logic [REG_CNT-1:1] wr_hit;
  logic [REG_CNT-1:1] fin_hit;

  always_comb begin
    wr_hit  = '0;
    fin_hit = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      wr_hit[r]  = wr_en  && (wr_addr  == LOG_REG_CNT'(r));
      fin_hit[r] = fin_en && (fin_addr == LOG_REG_CNT'(r));
    end
  end

  // Per-register next state. Flush beats everything, rdy=0 freezes, and an
  // issue and finish to the same register cancel out even at the limits.
  // Otherwise increments saturate at max and decrements stop at zero.
  always_comb begin
    for (int r = 1; r < REG_CNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (rdy && !(wr_hit[r] && fin_hit[r])) begin
        if (wr_hit[r] && (cnt_q[r] != CNT_MAX)) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (fin_hit[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < REG_CNT; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < REG_CNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Issue-side full indication: look up the destination counter directly,
  // independent of wr_en and rdy so issue can stall before asserting wr_en.
  always_comb begin
    wr_full = 1'b0;
    for (int r = 1; r < REG_CNT; r++) begin
      if ((wr_addr == LOG_REG_CNT'(r)) && (cnt_q[r] == CNT_MAX)) begin
        wr_full = 1'b1;
      end
    end
  end

  // Query ports: each port independently muxes the addressed counter out of
  // the current state. Unmatched addresses (0 or out of range) read as zero.
  logic [CNT_W-1:0] port_val [NUM_RD];

  always_comb begin
    rd_busy = '0;
    rd_cnt  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      port_val[i] = '0;
      for (int r = 1; r < REG_CNT; r++) begin
        if (rd_addr[i*LOG_REG_CNT +: LOG_REG_CNT] == LOG_REG_CNT'(r)) begin
          port_val[i] = cnt_q[r];
        end
      end
      if (rd_en[i]) begin
        rd_cnt[i*CNT_W +: CNT_W] = port_val[i];
        rd_busy[i]               = (port_val[i] != '0);
      end
    end
  end

`ifdef SCOREBOARD_ERR_CHECK_EN
  logic err_event;
  logic sb_err_q;

  // An overflow or underflow attempt only counts on a cycle that would
  // otherwise update state; same-register issue+finish pairs are legal.
  always_comb begin
    err_event = 1'b0;
    if (!flush && rdy) begin
      for (int r = 1; r < REG_CNT; r++) begin
        if (wr_hit[r] && !fin_hit[r] && (cnt_q[r] == CNT_MAX)) begin
          err_event = 1'b1;
        end
        if (fin_hit[r] && !wr_hit[r] && (cnt_q[r] == '0)) begin
          err_event = 1'b1;
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q <= 1'b0;
    end else if (err_event) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;
`else
  assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard_counter_multi.sv
// tb_scoreboard_counter_multi
//
// Scoreboard-style bench for scoreboard_counter_multi. The stimulus process
// drives one set of inputs per cycle, computes the expected outputs for that
// cycle from a plain integer-array model of pending writes, pushes them into
// a queue and then advances the model by the update the next edge applies.
// A monitor process pops one entry per cycle on the falling edge and
// compares it against the DUT outputs.

module tb_scoreboard_counter_multi;

  localparam int REG_CNT = 32;
  localparam int LOG_REG_CNT = 5;
  localparam int CNT_W = 3;
  localparam int NUM_RD = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                          clk;
  logic                          rst_n;
  logic                          rdy;
  logic                          flush;
  logic                          wr_en;
  logic [LOG_REG_CNT-1:0]        wr_addr;
  logic                          wr_full;
  logic                          fin_en;
  logic [LOG_REG_CNT-1:0]        fin_addr;
  logic [NUM_RD-1:0]             rd_en;
  logic [NUM_RD*LOG_REG_CNT-1:0] rd_addr;
  logic [NUM_RD-1:0]             rd_busy;
  logic [NUM_RD*CNT_W-1:0]       rd_cnt;
  logic                          sb_err;

  scoreboard_counter_multi #(
    .REG_CNT(REG_CNT), .LOG_REG_CNT(LOG_REG_CNT), .CNT_W(CNT_W), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_full(wr_full),
    .fin_en(fin_en), .fin_addr(fin_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_cnt(rd_cnt),
    .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RD-1:0]       busy;
    logic [NUM_RD*CNT_W-1:0] cnt;
    logic                    full;
    logic                    err;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt [REG_CNT];
  bit   model_err;
  int   checks_total;
  int   checks_passed;

`ifdef SCOREBOARD_ERR_CHECK_EN
  localparam bit ERR_CHECK = 1'b1;
`else
  localparam bit ERR_CHECK = 1'b0;
`endif

  function automatic bit addr_valid(input int a);
    return (a != 0) && (a < REG_CNT);
  endfunction

  function automatic int model_read(input int a);
    return addr_valid(a) ? model_cnt[a] : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // One cycle of stimulus: drive, record expected outputs for this cycle,
  // then advance the model by what the next rising edge should do.
  task automatic applyStimulus(input bit r, input bit f, input bit we, input int wa,
                               input bit fe, input int fa, input logic [NUM_RD-1:0] re,
                               input int a0, input int a1, input int a2);
    exp_t e;
    int   qa [NUM_RD];
    @(posedge clk);
    #1;
    qa[0] = a0; qa[1] = a1; qa[2] = a2;
    rdy = r; flush = f; wr_en = we; fin_en = fe;
    wr_addr = LOG_REG_CNT'(wa); fin_addr = LOG_REG_CNT'(fa); rd_en = re;
    for (int i = 0; i < NUM_RD; i++) rd_addr[i*LOG_REG_CNT +: LOG_REG_CNT] = LOG_REG_CNT'(qa[i]);

    e = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      int v;
      v = re[i] ? model_read(qa[i]) : 0;
      e.cnt[i*CNT_W +: CNT_W] = CNT_W'(v);
      e.busy[i] = (v > 0);
    end
    e.full = (model_read(wa) == CNT_MAX);
    e.err  = model_err;
    exp_q.push_back(e);

    if (f) begin
      foreach (model_cnt[k]) model_cnt[k] = 0;
    end else if (r) begin
      bit wv, fv;
      wv = we && addr_valid(wa);
      fv = fe && addr_valid(fa);
      if (!(wv && fv && wa == fa)) begin
        if (wv) begin
          if (model_cnt[wa] < CNT_MAX) model_cnt[wa]++;
          else if (ERR_CHECK) model_err = 1'b1;
        end
        if (fv) begin
          if (model_cnt[fa] > 0) model_cnt[fa]--;
          else if (ERR_CHECK) model_err = 1'b1;
        end
      end
    end
  endtask

  // Shorthands for the directed part.
  task automatic issue(input int a, input int q);
    applyStimulus(1, 0, 1, a, 0, 0, 3'b001, q, 0, 0);
  endtask

  task automatic finish(input int a, input int q);
    applyStimulus(1, 0, 0, 0, 1, a, 3'b001, q, 0, 0);
  endtask

  task automatic query(input int a0, input int a1, input int a2, input int wa);
    applyStimulus(1, 0, 0, wa, 0, 0, 3'b111, a0, a1, a2);
  endtask

  function automatic int rand_addr();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return 0;
      1: return 3;
      2: return 5;
      3: return 7;
      4: return 31;
      5: return 10;
      default: return int'($urandom_range(0, REG_CNT - 1));
    endcase
  endfunction

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 40) == 0,
                    $urandom_range(0, 2) != 0, rand_addr(),
                    $urandom_range(0, 2) == 0, rand_addr(),
                    NUM_RD'($urandom_range(0, 7)), rand_addr(), rand_addr(), rand_addr());
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic async_reset_check();
    @(posedge clk);
    #1;
    rdy = 1; flush = 0; wr_en = 0; fin_en = 0; wr_addr = 5'd5; fin_addr = '0;
    rd_en = 3'b111;
    rd_addr = {5'd31, 5'd0, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(rd_busy), 32'd0);
    checkOutput("async_rst_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("async_rst_full", 32'(wr_full), 32'd0);
    checkOutput("async_rst_err", 32'(sb_err), 32'd0);
    foreach (model_cnt[k]) model_cnt[k] = 0;
    model_err = 1'b0;
    exp_q.push_back('0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rd_busy", 32'(rd_busy), 32'(e.busy));
        checkOutput("rd_cnt", 32'(rd_cnt), 32'(e.cnt));
        checkOutput("wr_full", 32'(wr_full), 32'(e.full));
        checkOutput("sb_err", 32'(sb_err), 32'(e.err));
      end
    end
  end

  initial begin
    checks_total = 0;
    checks_passed = 0;
    model_err = 1'b0;
    foreach (model_cnt[k]) model_cnt[k] = 0;
    rst_n = 1'b0; rdy = 0; flush = 0; wr_en = 0; fin_en = 0;
    wr_addr = '0; fin_addr = '0; rd_en = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state seen through all ports.
    query(5, 0, 31, 5);

    // Issue/finish sequence on x5.
    issue(5, 5);
    issue(5, 5);
    issue(5, 5);
    query(5, 5, 5, 5);
    finish(5, 5);
    finish(5, 5);
    finish(5, 5);
    query(5, 0, 31, 5);

    // Simultaneous events.
    issue(7, 7);
    issue(7, 7);
    applyStimulus(1, 0, 1, 7, 1, 7, 3'b001, 7, 0, 0);
    issue(9, 9);
    applyStimulus(1, 0, 1, 3, 1, 9, 3'b011, 3, 9, 0);
    query(3, 9, 7, 3);

    // Saturation on x10, then one more issue, then a finish.
    for (int k = 0; k < 7; k++) issue(10, 10);
    query(10, 10, 0, 10);
    issue(10, 10);
    query(10, 10, 0, 10);
    finish(10, 10);
    query(10, 0, 0, 10);

    // Underflow on x12 and writes to x0.
    finish(12, 12);
    issue(0, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 3'b111, 0, 12, 0);
    query(0, 12, 0, 0);

    // Stall and flush.
    applyStimulus(0, 0, 1, 4, 0, 0, 3'b001, 4, 0, 0);
    issue(4, 4);
    issue(4, 4);
    issue(6, 6);
    applyStimulus(0, 0, 1, 4, 0, 0, 3'b011, 4, 6, 0);
    applyStimulus(0, 1, 1, 8, 1, 6, 3'b111, 4, 6, 8);
    query(4, 6, 8, 8);

    random_cycles(400);

    // Make sure counters are nonzero before the asynchronous reset.
    issue(5, 5);
    issue(31, 31);
    query(5, 0, 31, 31);
    async_reset_check();
    query(5, 0, 31, 5);

    random_cycles(200);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks_total++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/scoreboard_counter_multi.md
Name: scoreboard_counter_multi

Overview:
Parametrised register-dependency scoreboard for the issue stage. Keeps one saturating pending-write counter per architectural register. Issue increments the counter for the destination register; writeback/commit decrements it. Any number of read ports query the busy status so issue can stall on RAW/WAW hazards. Adds a global flush, a counter-full indication and optional error detection.

Parameters:
REG_CNT, 32, number of architectural registers (register 0 hardwired, never busy)
LOG_REG_CNT, 5, register address width, clog2(REG_CNT)
CNT_W, 3, counter width; max pending writes per register = 2^CNT_W-1
NUM_RD, 3, number of query ports

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; 0 freezes all state except flush
flush  in  1  clear all counters (branch mispredict / exception)
wr_en  in  1  issue of an instruction writing wr_addr
wr_addr  in  LOG_REG_CNT  destination register at issue
wr_full  out  1  counter[wr_addr]==max (combinational); issue must stall
fin_en  in  1  write completed for fin_addr
fin_addr  in  LOG_REG_CNT  completed destination register
rd_en  in  NUM_RD  per-port query enable
rd_addr  in  NUM_RD*LOG_REG_CNT  packed query addresses, port i at bits [i*LOG_REG_CNT +: LOG_REG_CNT]
rd_busy  out  NUM_RD  port i: rd_en[i] && counter!=0
rd_cnt  out  NUM_RD*CNT_W  port i counter value, 0 when rd_en[i]=0
sb_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): all counters 0, sb_err 0. All outputs are combinational from counters, so they read 0.
- Reads are combinational from current state, with no bypass. A query in the same cycle as wr_en/fin_en sees the pre-edge value. The update is visible the next cycle (1-cycle latency).
- Update priority at posedge, when rst_n is high:
  1. flush=1: all counters become 0. rdy, wr_en and fin_en are ignored that cycle.
  2. Otherwise, rdy=0: no change.
  3. Otherwise, wr_en and fin_en on the same nonzero addr: counter unchanged (net zero), even when full or zero.
  4. Otherwise, apply each independently:
     - wr_en: +1, unless the counter is at max; then ignored (saturate).
     - fin_en: -1, unless the counter is 0; then ignored (no underflow).
- Address 0: writes and finishes are ignored. Counter[0] is constant 0. Queries of 0 return busy=0 and cnt=0. wr_full is 0 for wr_addr=0.
- Addresses >= REG_CNT (when not a power of 2): treated like address 0.
- wr_full = counter[wr_addr]==2^CNT_W-1, independent of wr_en and rdy.
- Multiple read ports may address the same register; each returns an identical result.
- No FSM. State is REG_CNT-1 counters of CNT_W bits. Next-state logic is per register, using addr-decode one-hot masks so that dual updates never collide.

Optional Feature:
- Macro: SCOREBOARD_ERR_CHECK_EN.
- Defined: sb_err sets (sticky until reset) on the first enabled, non-flushed, rdy=1 cycle with either:
  - wr_en to a nonzero addr whose counter is at max, without a same-addr fin_en; or
  - fin_en to a nonzero addr whose counter is 0, without a same-addr wr_en.
  Counter behaviour is the same as the saturating behaviour above.
- Undefined: the check logic is absent and sb_err is tied 0.

Test Plan:
- Reset, then query: assert rst_n=0 mid-run with counters nonzero. Outputs drop to 0 asynchronously before the next edge. Query ports 0..2 on x5, x0 and x31 -> rd_busy=000, rd_cnt all 0.
- Issue/finish sequence:
  - Cycle 1: wr_en x5. Port 0 reads x5 in cycle 1 -> busy=0. Cycle 2 -> busy=1, cnt=1.
  - Cycles 2 and 3: wr_en x5 again -> cnt=3 by cycle 4.
  - Three fin_en x5 -> cnt=0, busy=0.
- Simultaneous events:
  - wr_en x7 and fin_en x7 with cnt=2 -> stays 2.
  - wr_en x3 and fin_en x9, with x3=0 and x9=1 -> x3=1, x9=0 next cycle.
- Saturation (CNT_W=3):
  - 7 issues to x10 -> cnt=7, wr_full=1.
  - 8th issue -> cnt stays 7. With the macro defined, sb_err=1 next cycle.
  - fin_en x10 -> cnt=6, wr_full=0.
- Underflow and x0:
  - fin_en x12 at 0 -> stays 0. sb_err=1 if the macro is defined, else 0.
  - wr_en x0 -> query x0 busy=0.
- Stall and flush:
  - rdy=0 with wr_en x4 -> x4 unchanged.
  - Counters x4=2, x6=1, then flush=1 with rdy=0 and wr_en x8 -> next cycle all counters 0, including x8.
